cordiv_ctrl: RTL and testbench

- Job sequencer for one external CORDIV stochastic divider kernel: accepts a binary dividend/divisor pair over a valid/ready handshake.
- Generates correlated unipolar bitstreams from a shared low-discrepancy source, clears and drives the kernel for 2^BITW cycles, and counts the quotient ones.
- Returns the binary quotient over a second valid/ready handshake.
- Sits between a binary-domain producer/consumer and the unary divider datapath.

---
 rtl/cordiv_ctrl.sv | 157 +++++++++++++++
 tb/tb_cordiv_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cordiv_ctrl.sv
// Job sequencer for one external CORDIV stochastic divider kernel.
// Optional abort input is enabled by defining CORDIV_CTRL_ABORT_EN.
module cordiv_ctrl #(
  parameter int BITW   = 8,
  parameter int DEPLOG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BITW-1:0]   in_dividend,
  input  logic [BITW-1:0]   in_divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BITW-1:0]   out_quotient,
  output logic              out_div0,
  output logic              kern_rst_n,
  output logic              kern_dividend,
  output logic              kern_divisor,
  output logic [DEPLOG-1:0] kern_randNum,
  input  logic              kern_quotient
`ifdef CORDIV_CTRL_ABORT_EN
  ,
  input  logic              abort
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE
  } state_t;

  localparam logic [BITW-1:0] QMAX = '1;

  state_t          state;
  state_t          state_nx;
  logic [BITW-1:0] dvd_r;
  logic [BITW-1:0] dvs_r;
  logic [BITW-1:0] cnt;
  logic [BITW-1:0] rng;
  logic [BITW-1:0] sat;
  logic [BITW:0]   acc;
  logic [BITW:0]   acc_sum;
  logic [7:0]      lfsr;
  logic            fb;
  logic            last;
  logic            kill;

`ifdef CORDIV_CTRL_ABORT_EN
  assign kill = abort && (state == CLEAR || state == RUN);
`else
  assign kill = 1'b0;
`endif

  assign last    = (cnt == QMAX);
  assign fb      = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign acc_sum = acc + {{BITW{1'b0}}, kern_quotient};
  assign sat     = acc_sum[BITW] ? QMAX : acc_sum[BITW-1:0];

  // Bit-reversed count is a van der Corput sequence shared by both streams.
  always_comb begin
    rng = '0;
    for (int i = 0; i < BITW; i++) begin
      rng[i] = cnt[BITW-1-i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    in_ready      = 1'b0;
    kern_rst_n    = 1'b1;
    kern_dividend = 1'b0;
    kern_divisor  = 1'b0;
    kern_randNum  = '0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = CLEAR;
      end
      CLEAR: begin
        kern_rst_n = 1'b0;
        state_nx   = RUN;
      end
      RUN: begin
        kern_dividend = (rng < dvd_r);
        kern_divisor  = (rng < dvs_r);
        kern_randNum  = lfsr[DEPLOG-1:0];
        if (last) state_nx = DONE;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (kill) begin
      state_nx   = IDLE;
      kern_rst_n = 1'b0;
    end
    if (rst) begin
      in_ready   = 1'b0;
      kern_rst_n = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_r        <= '0;
      dvs_r        <= '0;
      cnt          <= '0;
      acc          <= '0;
      lfsr         <= 8'h01;
      out_valid    <= 1'b0;
      out_quotient <= '0;
      out_div0     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            dvd_r <= in_dividend;
            dvs_r <= in_divisor;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc  <= acc_sum;
          cnt  <= cnt + 1'b1;
          lfsr <= {lfsr[6:0], fb};
          if (last && !kill) begin
            out_valid    <= 1'b1;
            out_div0     <= (dvs_r == '0);
            out_quotient <= (dvs_r == '0) ? QMAX : sat;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
      if (kill) begin
        acc <= '0;
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cordiv_ctrl.sv
// Self-checking bench for cordiv_ctrl with a behavioural CORDIV kernel.
// Abort sequences are exercised when CORDIV_CTRL_ABORT_EN is defined.
module tb_cordiv_ctrl;

  localparam int BITW   = 8;
  localparam int DEPLOG = 1;
  localparam int N      = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [BITW-1:0]   in_dividend;
  logic [BITW-1:0]   in_divisor;
  logic              out_valid;
  logic              out_ready;
  logic [BITW-1:0]   out_quotient;
  logic              out_div0;
  logic              kern_rst_n;
  logic              kern_dividend;
  logic              kern_divisor;
  logic [DEPLOG-1:0] kern_randNum;
  logic              kern_quotient;
`ifdef CORDIV_CTRL_ABORT_EN
  logic              abort;
`endif

  logic [1:0] ksr;
  logic [7:0] m_lfsr;
  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] dvd;
    logic [7:0] dvs;
    int         hold;
    int         qlo;
    int         qhi;
    bit         div0;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  cordiv_ctrl #(.BITW(BITW), .DEPLOG(DEPLOG)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_dividend  (in_dividend),
    .in_divisor   (in_divisor),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_quotient (out_quotient),
    .out_div0     (out_div0),
    .kern_rst_n   (kern_rst_n),
    .kern_dividend(kern_dividend),
    .kern_divisor (kern_divisor),
    .kern_randNum (kern_randNum),
    .kern_quotient(kern_quotient)
`ifdef CORDIV_CTRL_ABORT_EN
    ,
    .abort        (abort)
`endif
  );

  // CORDIV kernel: pass dividend when divisor is 1, else replay a past quotient.
  assign kern_quotient = kern_divisor ? kern_dividend : ksr[kern_randNum];

  always @(posedge clk) begin
    if (!kern_rst_n) ksr <= '0;
    else ksr <= {ksr[0], kern_quotient};
  end

  function automatic logic [7:0] brev(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act,
                             input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic watch_no_valid(input string name);
    int seen;
    seen = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check(name, seen, 0);
    check({name, "_ready"}, int'(in_ready), 1);
  endtask

  // cut_kind: 0 none, 1 reset at cut_lat, 2 abort at cut_lat.
  task automatic run_job(input logic [7:0] dvd, input logic [7:0] dvs,
                         input int hold, input int qlo, input int qhi,
                         input bit div0, input int cut_lat,
                         input int cut_kind);
    int lat, w, ones, clr, bad_s, bad_rn, bad_idle, bad_hold, exp_q;
    logic [7:0] rng;
    @(negedge clk);
    in_dividend = dvd;
    in_divisor  = dvs;
    in_valid    = 1'b1;
    w = 0;
    while (!in_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("in_accept", int'(in_ready), 1);
    lat = 0; ones = 0; clr = 0;
    bad_s = 0; bad_rn = 0; bad_idle = 0;
    while (lat < 300) begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
      if (!kern_rst_n) clr++;
      if (lat >= 2 && lat < N + 2) begin
        rng = brev(8'(lat - 2));
        if (kern_dividend !== (rng < dvd)) bad_s++;
        if (kern_divisor !== (rng < dvs)) bad_s++;
        if (kern_randNum !== m_lfsr[DEPLOG-1:0]) bad_rn++;
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        if (kern_quotient) ones++;
      end else if (kern_dividend || kern_divisor || kern_randNum != '0) begin
        bad_idle++;
      end
      if (out_valid || lat == cut_lat) break;
    end
    check("stream_bits", bad_s, 0);
    check("randnum_seq", bad_rn, 0);
    check("kern_idle_zero", bad_idle, 0);
    check("clear_cycles", clr, 1);
    if (cut_kind == 1) begin
      rst = 1'b1;
      #1;
      check("rst_in_ready", int'(in_ready), 0);
      check("rst_kern_rst_n", int'(kern_rst_n), 0);
      check("rst_out_valid", int'(out_valid), 0);
      @(negedge clk);
      rst = 1'b0;
      m_lfsr = 8'h01;
      watch_no_valid("rst_no_valid");
      return;
    end
`ifdef CORDIV_CTRL_ABORT_EN
    if (cut_kind == 2) begin
      abort = 1'b1;
      #1;
      check("abort_kern_rst_n", int'(kern_rst_n), 0);
      @(negedge clk);
      abort = 1'b0;
      check("abort_idle_ready", int'(in_ready), 1);
      check("abort_out_valid", int'(out_valid), 0);
      watch_no_valid("abort_no_valid");
      return;
    end
`endif
    check("latency", lat, N + 2);
    exp_q = div0 ? 255 : (ones > 255 ? 255 : ones);
    check("quotient", int'(out_quotient), exp_q);
    check_range("quotient_range", int'(out_quotient), qlo, qhi);
    check("div0", int'(out_div0), int'(div0));
    bad_hold = 0;
    for (int h = 0; h < hold; h++) begin
      in_dividend = 8'd1;
      in_divisor  = 8'd1;
      in_valid    = 1'b1;
      @(negedge clk);
      if (!out_valid || out_quotient != exp_q[7:0] ||
          out_div0 != div0 || in_ready) bad_hold++;
    end
    if (hold > 0) check("hold_stable", bad_hold, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", int'(out_valid), 0);
    check("release_ready", int'(in_ready), 1);
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    out_ready   = 1'b0;
`ifdef CORDIV_CTRL_ABORT_EN
    abort       = 1'b0;
`endif
    m_lfsr      = 8'h01;

    vecs[0] = '{8'd64,  8'd128, 0,  96,  160, 1'b0};
    vecs[1] = '{8'd255, 8'd255, 0,  255, 255, 1'b0};
    vecs[2] = '{8'd0,   8'd200, 0,  0,   8,   1'b0};
    vecs[3] = '{8'd37,  8'd0,   20, 255, 255, 1'b1};
    vecs[4] = '{8'd200, 8'd100, 3,  220, 255, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_in_ready", int'(in_ready), 0);
    check("reset_kern_rst_n", int'(kern_rst_n), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_quotient", int'(out_quotient), 0);
    check("reset_div0", int'(out_div0), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", int'(in_ready), 1);
    check("idle_kern_rst_n", int'(kern_rst_n), 1);

    for (int i = 0; i < 5; i++) begin
      run_job(vecs[i].dvd, vecs[i].dvs, vecs[i].hold,
              vecs[i].qlo, vecs[i].qhi, vecs[i].div0, 0, 0);
    end

    run_job(8'd64, 8'd128, 0, 0, 255, 1'b0, 102, 1);
    run_job(8'd96, 8'd192, 0, 96, 160, 1'b0, 0, 0);

`ifdef CORDIV_CTRL_ABORT_EN
    run_job(8'd64, 8'd128, 0, 0, 255, 1'b0, 52, 2);
    run_job(8'd64, 8'd128, 0, 96, 160, 1'b0, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
